// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters.
// Grants one byte per frame, launches it, and tracks the UART busy handshake with a start timeout.
module uart_tx_arbiter #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned START_TIMEOUT = 4
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [NUM_REQ-1:0]              REQ,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   REQ_DATA,
    output logic [NUM_REQ-1:0]              GNT,
    output logic [DATA_WIDTH-1:0]           TX_P_DATA,
    output logic                            TX_DATA_VALID,
    input  logic                            TX_BUSY,
    output logic [$clog2(NUM_REQ)-1:0]      CUR_ID,
    output logic                            ARB_BUSY,
    output logic                            TIMEOUT_ERR
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_START,
        WAIT_END
    } state_e;

    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [ID_W-1:0]        cur_id_q, cur_id_d;
    logic [ID_W-1:0]        last_id_q, last_id_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   tx_valid_q, tx_valid_d;
    logic                   arb_busy_q, arb_busy_d;
    logic                   timeout_q, timeout_d;
    logic                   arb_en_q;
    logic [NUM_REQ-1:0]     gnt_c;

    logic                   win_found;
    logic [ID_W-1:0]        win_id;
    logic [ID_W-1:0]        cand;

    // Round-robin search starting just after the last served requester
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((32'(last_id_q) + 32'd1 + i) % NUM_REQ);
            if (!win_found && REQ[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    // Next-state and output decode; GNT is the combinational capture strobe of the IDLE cycle
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        cur_id_d  = cur_id_q;
        last_id_d = last_id_q;
        cnt_d     = '0;
        timeout_d = 1'b0;
        gnt_c     = '0;

        case (state_q)
            IDLE: begin
                if (arb_en_q && !TX_BUSY && win_found) begin
                    gnt_c[win_id] = 1'b1;
                    data_d        = REQ_DATA[32'(win_id)*DATA_WIDTH +: DATA_WIDTH];
                    cur_id_d      = win_id;
                    last_id_d     = win_id;
                    state_d       = SEND;
                end
            end
            SEND: begin
                state_d = WAIT_START;
            end
            WAIT_START: begin
                if (TX_BUSY) begin
                    state_d = WAIT_END;
                end else if (cnt_q + CNT_W'(1) == CNT_W'(START_TIMEOUT)) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_END: begin
                if (!TX_BUSY) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        tx_valid_d = (state_d == SEND);
        arb_busy_d = (state_d != IDLE);
    end

    // arb_en_q holds off arbitration until the first clock edge after reset release
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            data_q     <= '0;
            cur_id_q   <= '0;
            last_id_q  <= ID_W'(NUM_REQ - 1);
            cnt_q      <= '0;
            tx_valid_q <= 1'b0;
            arb_busy_q <= 1'b0;
            timeout_q  <= 1'b0;
            arb_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            cur_id_q   <= cur_id_d;
            last_id_q  <= last_id_d;
            cnt_q      <= cnt_d;
            tx_valid_q <= tx_valid_d;
            arb_busy_q <= arb_busy_d;
            timeout_q  <= timeout_d;
            arb_en_q   <= 1'b1;
        end
    end

    assign GNT           = gnt_c;
    assign TX_P_DATA     = data_q;
    assign TX_DATA_VALID = tx_valid_q;
    assign CUR_ID        = cur_id_q;
    assign ARB_BUSY      = arb_busy_q;
    assign TIMEOUT_ERR   = timeout_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of one transmit byte; SHALL match the UART TX data width.
REQ-002 Parameter NUM_REQ, default 4: number of requesters sharing one UART TX; legal range 2..8.
REQ-003 Parameter START_TIMEOUT, default 4: maximum cycles to wait for TX_BUSY to rise after a launch.
REQ-004 The block has one clock, and reset is asynchronous and active-low.
REQ-005 Ports SHALL be as follows:
- CLK  in  1  clock; same clock as the shared UART TX.
- RST  in  1  asynchronous active-low reset.
- REQ  in  NUM_REQ  per-requester request, level.
- REQ_DATA  in  NUM_REQ*DATA_WIDTH  per-requester byte; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- GNT  out  NUM_REQ  one-hot, one-cycle pulse: the requester's byte has been captured.
- TX_P_DATA  out  DATA_WIDTH  byte to the UART TX.
- TX_DATA_VALID  out  1  one-cycle launch pulse to the UART TX.
- TX_BUSY  in  1  UART TX busy flag.
- CUR_ID  out  $clog2(NUM_REQ)  index of the requester being served.
- ARB_BUSY  out  1  high in every state except IDLE.
- TIMEOUT_ERR  out  1  one-cycle pulse when TX_BUSY fails to rise.

Function
REQ-006 The FSM SHALL have exactly the states IDLE, SEND, WAIT_START and WAIT_END.
REQ-007 IDLE SHALL arbitrate only when TX_BUSY=0 and REQ is non-zero; otherwise it remains in IDLE.
REQ-008 Arbitration SHALL be round-robin: the search starts at (last_id+1) mod NUM_REQ and picks the first set REQ bit.
REQ-009 On a winning arbitration the block SHALL, in the same cycle:
- assert GNT[winner] for one cycle;
- capture the winner's REQ_DATA slice into a holding register;
- load CUR_ID and last_id with the winner;
- go to SEND.
REQ-010 A requester SHALL treat GNT as consumption of its byte and may change REQ_DATA or drop REQ in the next cycle; the held byte SHALL be unaffected.
REQ-011 In SEND, TX_DATA_VALID SHALL be 1 for exactly one cycle with TX_P_DATA equal to the held byte; the next state is WAIT_START.
REQ-012 TX_P_DATA SHALL hold the captured byte stable from SEND until the next capture.
REQ-013 WAIT_START SHALL behave as follows:
- TX_BUSY=1 -> WAIT_END.
- Otherwise an internal counter, cleared on entering the state, increments.
- When the counter reaches START_TIMEOUT with TX_BUSY still 0 -> pulse TIMEOUT_ERR for one cycle and go to IDLE; the byte is dropped and there is no retry.
REQ-014 WAIT_END SHALL go to IDLE in the first cycle TX_BUSY=0.
REQ-015 The minimum spacing between two GNT pulses SHALL be 4 cycles (IDLE, SEND, WAIT_START, WAIT_END with one-cycle busy), plus the frame duration.
REQ-016 REQ bits that change while the FSM is outside IDLE SHALL have no effect until the next IDLE evaluation.
REQ-017 If REQ drops before being granted, that requester SHALL NOT be granted.
REQ-018 At most one GNT bit SHALL be high in any cycle.
REQ-019 TX_DATA_VALID SHALL never be asserted while the FSM is outside SEND.
REQ-020 last_id arithmetic SHALL wrap modulo NUM_REQ, including when NUM_REQ is not a power of two.
REQ-021 ARB_BUSY SHALL be a registered decode of state != IDLE, or combinationally equivalent to it.

Reset
REQ-022 RST=0 SHALL immediately force:
- state = IDLE;
- GNT = 0, TX_DATA_VALID = 0, TIMEOUT_ERR = 0, ARB_BUSY = 0;
- TX_P_DATA = 0, CUR_ID = 0;
- last_id = NUM_REQ-1, so requester 0 has first priority;
- timeout counter = 0.
REQ-023 Reset asserted mid-transfer SHALL abandon the transfer with no GNT or TX_DATA_VALID emitted.
REQ-024 After RST deasserts, the first arbitration SHALL occur no earlier than the first rising CLK edge.

Verification
REQ-025 Single request: REQ=0001, REQ_DATA[7:0]=8'hA5, TX_BUSY rises 1 cycle after launch and stays high 10 cycles. Required response:
- GNT=0001 for 1 cycle;
- next cycle TX_DATA_VALID=1 with TX_P_DATA=8'hA5;
- ARB_BUSY falls the cycle after TX_BUSY falls.
REQ-026 Round-robin: REQ=1111 held, bytes 8'h10/8'h20/8'h30/8'h40 on requesters 0/1/2/3. Required response:
- grant order 0,1,2,3,0;
- TX_P_DATA sequence 8'h10, 8'h20, 8'h30, 8'h40, 8'h10.
REQ-027 Skip and wrap: after a grant to requester 2, REQ=0011 -> next grant is requester 0, then requester 1.
REQ-028 Timeout: REQ=0100 with TX_BUSY tied 0. Required response:
- one TX_DATA_VALID pulse;
- TIMEOUT_ERR pulses exactly START_TIMEOUT cycles after entering WAIT_START;
- FSM returns to IDLE, then re-grants requester 2.
REQ-029 Blocked start: TX_BUSY=1 while in IDLE with REQ=0001 -> no GNT until TX_BUSY=0.
REQ-030 Reset mid-frame: assert RST=0 during WAIT_END. Required response:
- all outputs at reset values immediately;
- after release with REQ=1000, the first grant goes to requester 3, i.e. no stale last_id.
